// File: rtl/shift_rotate_pipe.sv
// shift_rotate_pipe
// Pipelined shifter/rotator: one stage per bit of the shift count.
// Stage k shifts or rotates by 2^k when count bit k is set, otherwise passes
// data through. The whole pipe advances together (global stall), so an
// empty slot stays an empty slot and results leave in input order.
//
// Op encoding: 00 ROL, 01 SLL, 10 ROR, 11 SRA.

module shift_rotate_pipe #(
    parameter int WIDTH = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [WIDTH-1:0]           In,
    input  logic [$clog2(WIDTH)-1:0]   Cnt,
    input  logic [1:0]                 Op,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [WIDTH-1:0]           Out,
    output logic                       Zero
);

    localparam int SHW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        OP_ROL = 2'b00,
        OP_SLL = 2'b01,
        OP_ROR = 2'b10,
        OP_SRA = 2'b11
    } op_e;

    // One shift/rotate step of fixed size 2^k. The shift amounts are
    // constants once the stage loop unrolls, so each stage is a single 2:1
    // mux level plus the fill select for the vacated bits.
    function automatic logic [WIDTH-1:0] stage_op(
        input logic [WIDTH-1:0] d,
        input logic [1:0]       op,
        input logic             sgn,
        input logic             en,
        input int               k
    );
        int               amt;
        logic [WIDTH-1:0] fill_mask;
        logic [WIDTH-1:0] res;
        amt       = 1 << k;
        fill_mask = ~({WIDTH{1'b1}} >> amt);
        res       = d;
        if (en) begin
            case (op_e'(op))
                OP_ROL:  res = (d << amt) | (d >> (WIDTH - amt));
                OP_SLL:  res = d << amt;
                OP_ROR:  res = (d >> amt) | (d << (WIDTH - amt));
                OP_SRA:  res = (d >> amt) | (sgn ? fill_mask : '0);
                default: res = d;
            endcase
        end
        return res;
    endfunction

    logic [WIDTH-1:0] data_q [SHW];
    logic [SHW-1:0]   cnt_q  [SHW];
    logic [1:0]       op_q   [SHW];
    logic [SHW-1:0]   sign_q;
    logic [SHW-1:0]   valid_q;

    logic [WIDTH-1:0] src_data [SHW];
    logic [SHW-1:0]   src_cnt  [SHW];
    logic [1:0]       src_op   [SHW];
    logic [SHW-1:0]   src_sign;
    logic [SHW-1:0]   src_valid;
    logic [WIDTH-1:0] data_d   [SHW];

    logic             advance;
    logic             unused_tail;

    // Stall only when a finished result is waiting and the consumer refuses it.
    assign advance   = ~out_valid | out_ready;
    assign in_ready  = advance;
    assign out_valid = valid_q[SHW-1];
    assign Out       = data_q[SHW-1];
    assign Zero      = out_valid & (Out == '0);

    // Stage inputs: stage 0 sees the operand port, later stages their predecessor.
    always_comb begin
        src_data[0]  = In;
        src_cnt[0]   = Cnt;
        src_op[0]    = Op;
        src_sign[0]  = In[WIDTH-1];
        src_valid[0] = in_valid;
        for (int k = 1; k < SHW; k++) begin
            src_data[k]  = data_q[k-1];
            src_cnt[k]   = cnt_q[k-1];
            src_op[k]    = op_q[k-1];
            src_sign[k]  = sign_q[k-1];
            src_valid[k] = valid_q[k-1];
        end
    end

    // Per-stage datapath: conditional 2^k shift/rotate selected by count bit k.
    always_comb begin
        for (int k = 0; k < SHW; k++) begin
            data_d[k] = stage_op(src_data[k], src_op[k], src_sign[k],
                                 src_cnt[k][k], k);
        end
    end

    // Control fields of the last stage travel with the result but nothing
    // downstream consumes them; fold them together so they stay visible.
    always_comb begin
        unused_tail = 1'b0;
        for (int k = 0; k < SHW; k++) begin
            unused_tail = unused_tail ^ (^cnt_q[k]);
        end
        unused_tail = unused_tail ^ (^op_q[SHW-1]) ^ sign_q[SHW-1];
    end

    // Pipeline registers: everything clears on reset, whole pipe moves on advance.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < SHW; k++) begin
                data_q[k] <= '0;
                cnt_q[k]  <= '0;
                op_q[k]   <= '0;
            end
            sign_q  <= '0;
            valid_q <= '0;
        end else if (advance) begin
            for (int k = 0; k < SHW; k++) begin
                data_q[k] <= data_d[k];
                cnt_q[k]  <= src_cnt[k];
                op_q[k]   <= src_op[k];
            end
            sign_q  <= src_sign;
            valid_q <= src_valid;
        end
    end

endmodule

// File: tb/tb_shift_rotate_pipe.sv
// Directed and randomized checks for shift_rotate_pipe at WIDTH=16 and 32.
module tb_shift_rotate_pipe;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // 16-bit instance
    logic        a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_zero;
    logic [15:0] a_in, a_out;
    logic [3:0]  a_cnt;
    logic [1:0]  a_op;

    // 32-bit instance
    logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_zero;
    logic [31:0] b_in, b_out;
    logic [4:0]  b_cnt;
    logic [1:0]  b_op;

    int tests  = 0;
    int errors = 0;

    shift_rotate_pipe #(.WIDTH(16)) dut16 (
        .clk(clk), .rst(rst),
        .in_valid(a_in_valid), .in_ready(a_in_ready),
        .In(a_in), .Cnt(a_cnt), .Op(a_op),
        .out_valid(a_out_valid), .out_ready(a_out_ready),
        .Out(a_out), .Zero(a_zero)
    );

    shift_rotate_pipe #(.WIDTH(32)) dut32 (
        .clk(clk), .rst(rst),
        .in_valid(b_in_valid), .in_ready(b_in_ready),
        .In(b_in), .Cnt(b_cnt), .Op(b_op),
        .out_valid(b_out_valid), .out_ready(b_out_ready),
        .Out(b_out), .Zero(b_zero)
    );

    typedef struct {
        logic [1:0]  op;
        logic [15:0] din;
        logic [3:0]  cnt;
        logic [15:0] exp;
    } vec_t;

    vec_t vecs [15] = '{
        '{2'b00, 16'h8001, 4'd1,  16'h0003},
        '{2'b00, 16'h8001, 4'd0,  16'h8001},
        '{2'b10, 16'h1234, 4'd4,  16'h4123},
        '{2'b01, 16'h00FF, 4'd8,  16'hFF00},
        '{2'b11, 16'h8000, 4'd15, 16'hFFFF},
        '{2'b11, 16'h4000, 4'd15, 16'h0000},
        '{2'b00, 16'h1234, 4'd4,  16'h2341},
        '{2'b01, 16'h8001, 4'd1,  16'h0002},
        '{2'b11, 16'h8001, 4'd0,  16'h8001},
        '{2'b10, 16'h0001, 4'd15, 16'h0002},
        '{2'b11, 16'h7FFF, 4'd4,  16'h07FF},
        '{2'b01, 16'hFFFF, 4'd15, 16'h8000},
        '{2'b10, 16'h8001, 4'd0,  16'h8001},
        '{2'b01, 16'hABCD, 4'd0,  16'hABCD},
        '{2'b11, 16'hF0F0, 4'd4,  16'hFF0F}
    };

    // Bit-by-bit reference for the 32-bit instance.
    function automatic logic [31:0] ref32(input logic [31:0] d, input logic [4:0] c,
                                          input logic [1:0] op);
        logic [31:0] r;
        int cc;
        cc = int'(c);
        r  = '0;
        for (int i = 0; i < 32; i++) begin
            case (op)
                2'b00: r[(i + cc) % 32] = d[i];
                2'b01: r[i] = (i >= cc) ? d[i - cc] : 1'b0;
                2'b10: r[i] = d[(i + cc) % 32];
                default: r[i] = (i + cc < 32) ? d[i + cc] : d[31];
            endcase
        end
        return r;
    endfunction

    // Issue one operation into an idle 16-bit pipe and wait for its result.
    task automatic run16(input logic [1:0] op, input logic [15:0] din, input logic [3:0] cnt,
                         output logic [15:0] res, output logic z, output int lat);
        @(negedge clk);
        a_in_valid  = 1'b1;
        a_in        = din;
        a_cnt       = cnt;
        a_op        = op;
        a_out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        a_in_valid = 1'b0;
        lat = 1;
        while (!a_out_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        res = a_out;
        z   = a_zero;
    endtask

    task automatic run32(input logic [1:0] op, input logic [31:0] din, input logic [4:0] cnt,
                         output logic [31:0] res, output int lat);
        @(negedge clk);
        b_in_valid  = 1'b1;
        b_in        = din;
        b_cnt       = cnt;
        b_op        = op;
        b_out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        b_in_valid = 1'b0;
        lat = 1;
        while (!b_out_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        res = b_out;
    endtask

    task automatic test_reset;
        #2;
        tests++; if (a_out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid16: got %b expected 0", a_out_valid); end
        tests++; if (a_out !== 16'h0) begin errors++; $display("FAIL reset_out16: got %h expected 0000", a_out); end
        tests++; if (a_zero !== 1'b0) begin errors++; $display("FAIL reset_zero16: got %b expected 0", a_zero); end
        tests++; if (a_in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready16: got %b expected 1", a_in_ready); end
        tests++; if (b_out_valid !== 1'b0 || b_out !== 32'h0) begin errors++; $display("FAIL reset_out32: got valid %b out %h expected 0 0", b_out_valid, b_out); end
        tests++; if (b_in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready32: got %b expected 1", b_in_ready); end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_ops;
        logic [15:0] res;
        logic        z;
        int          lat;
        for (int i = 0; i < 15; i++) begin
            run16(vecs[i].op, vecs[i].din, vecs[i].cnt, res, z, lat);
            tests++; if (lat !== 4) begin errors++; $display("FAIL op%0d_latency: got %0d expected 4", i, lat); end
            tests++; if (res !== vecs[i].exp) begin errors++; $display("FAIL op%0d_out: got %h expected %h", i, res, vecs[i].exp); end
            tests++; if (z !== (vecs[i].exp == 16'h0)) begin errors++; $display("FAIL op%0d_zero: got %b expected %b", i, z, vecs[i].exp == 16'h0); end
        end
    endtask

    task automatic test_backpressure;
        int          sent = 0, got = 0, stall = 0, cyc = 0, stall_seen = 0;
        bit          seen = 1'b0, prev_stall = 1'b0;
        logic [15:0] prev_out = '0;
        logic [15:0] got_v [6];
        while (got < 6 && cyc < 60) begin
            @(negedge clk);
            cyc++;
            if (prev_stall) begin
                tests++;
                if (a_out_valid !== 1'b1 || a_out !== prev_out) begin
                    errors++; $display("FAIL bp_hold: got valid %b out %h expected 1 %h", a_out_valid, a_out, prev_out);
                end
            end
            if (a_out_valid && !seen) begin seen = 1'b1; stall = 3; end
            a_out_ready = (stall == 0);
            if (stall > 0) stall--;
            a_in_valid = (sent < 6);
            a_in       = 16'(sent + 1);
            a_op       = 2'b00;
            a_cnt      = 4'd1;
            #1;
            tests++;
            if (a_in_ready !== (!a_out_valid || a_out_ready)) begin
                errors++; $display("FAIL bp_in_ready: got %b expected %b", a_in_ready, !a_out_valid || a_out_ready);
            end
            if (a_out_valid && !a_out_ready) stall_seen++;
            if (a_out_valid && a_out_ready) begin got_v[got] = a_out; got++; end
            if (a_in_valid && a_in_ready) sent++;
            prev_stall = a_out_valid && !a_out_ready;
            prev_out   = a_out;
        end
        a_in_valid  = 1'b0;
        a_out_ready = 1'b1;
        tests++; if (got !== 6) begin errors++; $display("FAIL bp_count: got %0d expected 6", got); end
        tests++; if (stall_seen !== 3) begin errors++; $display("FAIL bp_stall_cycles: got %0d expected 3", stall_seen); end
        for (int i = 0; i < got; i++) begin
            tests++;
            if (got_v[i] !== 16'(2 * (i + 1))) begin
                errors++; $display("FAIL bp_order%0d: got %h expected %h", i, got_v[i], 16'(2 * (i + 1)));
            end
        end
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            tests++; if (a_out_valid !== 1'b0) begin errors++; $display("FAIL bp_duplicate: got valid %b expected 0", a_out_valid); end
        end
    endtask

    task automatic test_reset_midflight;
        logic [15:0] res;
        logic        z;
        int          lat;
        a_out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            a_in_valid = 1'b1;
            a_in       = 16'(16'h0101 * (i + 1));
            a_op       = 2'b00;
            a_cnt      = 4'd1;
        end
        @(negedge clk);
        a_in_valid = 1'b0;
        @(negedge clk);
        tests++; if (a_out_valid !== 1'b1 || a_out !== 16'h0202) begin errors++; $display("FAIL mid_pre: got valid %b out %h expected 1 0202", a_out_valid, a_out); end
        #2;
        rst = 1'b1;
        #1;
        tests++; if (a_out_valid !== 1'b0) begin errors++; $display("FAIL mid_out_valid: got %b expected 0", a_out_valid); end
        tests++; if (a_out !== 16'h0) begin errors++; $display("FAIL mid_out: got %h expected 0000", a_out); end
        tests++; if (a_zero !== 1'b0) begin errors++; $display("FAIL mid_zero: got %b expected 0", a_zero); end
        tests++; if (a_in_ready !== 1'b1) begin errors++; $display("FAIL mid_in_ready: got %b expected 1", a_in_ready); end
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            tests++; if (a_out_valid !== 1'b0) begin errors++; $display("FAIL mid_flushed: got valid %b out %h expected 0", a_out_valid, a_out); end
        end
        run16(2'b10, 16'h00F0, 4'd4, res, z, lat);
        tests++; if (lat !== 4) begin errors++; $display("FAIL mid_after_latency: got %0d expected 4", lat); end
        tests++; if (res !== 16'h000F) begin errors++; $display("FAIL mid_after_out: got %h expected 000F", res); end
    endtask

    task automatic test_latency32;
        logic [31:0] res;
        int          lat;
        run32(2'b00, 32'h8000_0001, 5'd31, res, lat);
        tests++; if (lat !== 5) begin errors++; $display("FAIL lat32_a: got %0d expected 5", lat); end
        tests++; if (res !== 32'hC000_0000) begin errors++; $display("FAIL out32_a: got %h expected C0000000", res); end
        run32(2'b11, 32'h8000_0000, 5'd31, res, lat);
        tests++; if (lat !== 5) begin errors++; $display("FAIL lat32_b: got %0d expected 5", lat); end
        tests++; if (res !== 32'hFFFF_FFFF) begin errors++; $display("FAIL out32_b: got %h expected FFFFFFFF", res); end
    endtask

    task automatic test_random32;
        logic [31:0] exp_q [$];
        logic [31:0] e;
        int          sent = 0, got = 0, cyc = 0;
        while (got < 10000 && cyc < 40000) begin
            @(negedge clk);
            cyc++;
            b_out_ready = ($urandom_range(0, 3) != 0);
            b_in_valid  = (sent < 10000) && ($urandom_range(0, 9) < 7);
            b_in        = $urandom;
            b_cnt       = 5'($urandom_range(0, 31));
            b_op        = 2'($urandom_range(0, 3));
            #1;
            if (b_out_valid && b_out_ready) begin
                tests++;
                if (exp_q.size() == 0) begin
                    errors++; $display("FAIL rnd_extra: got %h expected no result", b_out);
                end else begin
                    e = exp_q.pop_front();
                    if (b_out !== e || b_zero !== (e == 32'h0)) begin
                        errors++; $display("FAIL rnd_out%0d: got %h zero %b expected %h zero %b", got, b_out, b_zero, e, e == 32'h0);
                    end
                end
                got++;
            end
            if (b_in_valid && b_in_ready) begin
                exp_q.push_back(ref32(b_in, b_cnt, b_op));
                sent++;
            end
        end
        b_in_valid  = 1'b0;
        b_out_ready = 1'b1;
        tests++; if (got !== 10000) begin errors++; $display("FAIL rnd_count: got %0d expected 10000", got); end
        tests++; if (exp_q.size() !== 0) begin errors++; $display("FAIL rnd_leftover: got %0d expected 0", exp_q.size()); end
    endtask

    initial begin
        a_in_valid = 1'b0; a_in = '0; a_cnt = '0; a_op = '0; a_out_ready = 1'b1;
        b_in_valid = 1'b0; b_in = '0; b_cnt = '0; b_op = '0; b_out_ready = 1'b1;
        test_reset;
        test_ops;
        test_backpressure;
        test_reset_midflight;
        test_latency32;
        test_random32;
        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule
